bin_to_bcd_seq: RTL and testbench

//  Iterative (shift-and-add-3) binary-to-BCD converter that sits directly upstream of the
//  hex 7-segment decoders. Turns a CPU register/PC value into packed decimal digits,
//  one nibble per display decoder, so the board shows decimal instead of hex.

---
 rtl/bin_to_bcd_seq_pkg.sv | 12 +
 rtl/bin_to_bcd_seq_bcd_add3.sv | 20 ++
 rtl/bin_to_bcd_seq.sv | 146 ++++++++++++++
 tb/tb_bin_to_bcd_seq.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bin_to_bcd_seq_pkg.sv
// Shared display-path definitions: FSM state encoding and the BCD digit width.
package bin_to_bcd_seq_pkg;

    localparam int BCD_DIGIT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/bin_to_bcd_seq_bcd_add3.sv
// Double-dabble digit correction: a digit of 5 or more gets +3 so the following
// left shift carries correctly into the next decimal digit.
module bcd_add3
    import bin_to_bcd_seq_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] i_digit,
    output logic [BCD_DIGIT_W-1:0] o_digit
);

    // Conditional +3 correction of one BCD digit
    always_comb begin
        o_digit = i_digit;
        if (i_digit >= 4'd5) begin
            o_digit = i_digit + 4'd3;
        end else begin
            o_digit = i_digit;
        end
    end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Iterative shift-and-add-3 binary-to-BCD converter, one bit per clock, feeding
// the 7-segment decoders with packed decimal digits held stable between results.
module bin_to_bcd_seq
    import bin_to_bcd_seq_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic                          start,
    input  logic [WIDTH-1:0]              bin,
    output logic                          busy,
    output logic                          done,
    output logic [BCD_DIGIT_W*DIGITS-1:0] bcd,
    output logic                          overflow
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam int BCD_W = BCD_DIGIT_W * DIGITS;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_count;
    logic [WIDTH-1:0]   r_shift;
    logic [BCD_W-1:0]   r_work;
    logic [BCD_W-1:0]   w_work_corr;
    logic [BCD_W-1:0]   w_work_nxt;
    logic               r_ovf;
    logic               w_ovf_nxt;
    logic               r_busy;
    logic               r_done;
    logic [BCD_W-1:0]   r_bcd;
    logic               r_overflow;
    logic               w_busy_nxt;
    logic               w_done_nxt;
    logic               w_accept;
    logic               w_last;

    genvar g;
    generate
        for (g = 0; g < DIGITS; g++) begin : g_add3
            bcd_add3 u_add3 (
                .i_digit (r_work[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
                .o_digit (w_work_corr[g*BCD_DIGIT_W +: BCD_DIGIT_W])
            );
        end
    endgenerate

    // Correction uses the pre-shift digits; the bit leaving the top digit flags overflow
    assign w_work_nxt = {w_work_corr[BCD_W-2:0], r_shift[WIDTH-1]};
    assign w_ovf_nxt  = r_ovf | w_work_corr[BCD_W-1];
    assign w_accept   = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_last     = (r_state == ST_SHIFT) && (r_count == CNT_W'(1));

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (start)  w_state_nxt = ST_SHIFT; else w_state_nxt = ST_IDLE;
            ST_SHIFT: if (w_last) w_state_nxt = ST_DONE;  else w_state_nxt = ST_SHIFT;
            ST_DONE:  if (start)  w_state_nxt = ST_SHIFT; else w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Output decode, registered below so no input reaches an output combinationally
    always_comb begin
        w_busy_nxt = 1'b0;
        w_done_nxt = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                w_busy_nxt = w_accept;
                w_done_nxt = 1'b0;
            end
            ST_SHIFT: begin
                w_busy_nxt = !w_last;
                w_done_nxt = w_last;
            end
            default: begin
                w_busy_nxt = 1'b0;
                w_done_nxt = 1'b0;
            end
        endcase
    end

    // Working registers: load on accept, one correct-and-shift step per SHIFT cycle
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_shift <= {WIDTH{1'b0}};
            r_work  <= {BCD_W{1'b0}};
            r_ovf   <= 1'b0;
            r_count <= {CNT_W{1'b0}};
        end else if (w_accept) begin
            r_shift <= bin;
            r_work  <= {BCD_W{1'b0}};
            r_ovf   <= 1'b0;
            r_count <= CNT_W'(WIDTH);
        end else if (r_state == ST_SHIFT) begin
            r_shift <= {r_shift[WIDTH-2:0], 1'b0};
            r_work  <= w_work_nxt;
            r_ovf   <= w_ovf_nxt;
            r_count <= r_count - CNT_W'(1);
        end else begin
            r_shift <= r_shift;
            r_work  <= r_work;
            r_ovf   <= r_ovf;
            r_count <= r_count;
        end
    end

    // Output registers: result only changes on the final step so decoders never see partials
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_bcd      <= {BCD_W{1'b0}};
            r_overflow <= 1'b0;
        end else begin
            r_busy <= w_busy_nxt;
            r_done <= w_done_nxt;
            if (w_last) begin
                r_bcd      <= w_work_nxt;
                r_overflow <= w_ovf_nxt;
            end else begin
                r_bcd      <= r_bcd;
                r_overflow <= r_overflow;
            end
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign bcd      = r_bcd;
    assign overflow = r_overflow;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Scoreboard bench for bin_to_bcd_seq: a 16-bit/5-digit instance and an
// 8-bit/2-digit instance that exercises the overflow flag.
module tb_bin_to_bcd_seq;

    typedef struct packed {
        logic [19:0] bcd;
        logic        ovf;
        int          cyc;
    } exp_t;

    logic        clock;
    logic        rst_n;
    logic        start16;
    logic [15:0] bin16;
    logic        busy16;
    logic        done16;
    logic [19:0] bcd16;
    logic        overflow16;
    logic        start8;
    logic [7:0]  bin8;
    logic        busy8;
    logic        done8;
    logic [7:0]  bcd8;
    logic        overflow8;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cycle    = 0;
    exp_t q16[$];
    exp_t q8[$];
    exp_t e16;
    exp_t e8;
    logic prev16 = 1'b0;
    logic prev8  = 1'b0;

    bin_to_bcd_seq #(.WIDTH(16), .DIGITS(5)) u_dut16 (
        .clock    (clock),
        .reset_n  (rst_n),
        .start    (start16),
        .bin      (bin16),
        .busy     (busy16),
        .done     (done16),
        .bcd      (bcd16),
        .overflow (overflow16)
    );

    bin_to_bcd_seq #(.WIDTH(8), .DIGITS(2)) u_dut8 (
        .clock    (clock),
        .reset_n  (rst_n),
        .start    (start8),
        .bin      (bin8),
        .busy     (busy8),
        .done     (done8),
        .bcd      (bcd8),
        .overflow (overflow8)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cycle <= cycle + 1;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Reference: decimal digits of v, truncated to nd digits
    function automatic logic [19:0] bcd_of(input int v, input int nd);
        logic [19:0] r;
        int          x;
        r = 20'd0;
        x = v;
        for (int i = 0; i < nd; i++) begin
            r[i*4 +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    always @(negedge clock) begin
        if (rst_n && done16) begin
            check_val("done16_width", {31'd0, prev16}, 32'd0);
            check_val("sb16_pending", {31'd0, (q16.size() > 0)}, 32'd1);
            if (q16.size() > 0) begin
                e16 = q16.pop_front();
                check_val("bcd16", {12'd0, bcd16}, {12'd0, e16.bcd});
                check_val("ovf16", {31'd0, overflow16}, {31'd0, e16.ovf});
                check_val("latency16", cycle, e16.cyc);
                check_val("busy16_in_done", {31'd0, busy16}, 32'd0);
            end
        end
        prev16 = done16;
    end

    always @(negedge clock) begin
        if (rst_n && done8) begin
            check_val("done8_width", {31'd0, prev8}, 32'd0);
            check_val("sb8_pending", {31'd0, (q8.size() > 0)}, 32'd1);
            if (q8.size() > 0) begin
                e8 = q8.pop_front();
                check_val("bcd8", {24'd0, bcd8}, {12'd0, e8.bcd});
                check_val("ovf8", {31'd0, overflow8}, {31'd0, e8.ovf});
                check_val("latency8", cycle, e8.cyc);
            end
        end
        prev8 = done8;
    end

    task automatic step();
        @(negedge clock);
        #1;
    endtask

    task automatic push16(input int v);
        q16.push_back('{bcd: bcd_of(v, 5), ovf: 1'b0, cyc: cycle + 17});
    endtask

    task automatic wait_drain16();
        for (int i = 0; i < 40; i++) begin
            if (q16.size() == 0) break;
            step();
        end
        check_val("drain16", q16.size(), 32'd0);
    endtask

    task automatic wait_drain8();
        for (int i = 0; i < 30; i++) begin
            if (q8.size() == 0) break;
            step();
        end
        check_val("drain8", q8.size(), 32'd0);
    endtask

    task automatic run16(input int v);
        start16 = 1'b1;
        bin16   = 16'(v);
        push16(v);
        step();
        start16 = 1'b0;
        bin16   = 16'($urandom);
        check_val("busy16_after_accept", {31'd0, busy16}, 32'd1);
        wait_drain16();
        step();
    endtask

    task automatic run8(input int v);
        start8 = 1'b1;
        bin8   = 8'(v);
        q8.push_back('{bcd: bcd_of(v, 2), ovf: (v >= 100), cyc: cycle + 9});
        step();
        start8 = 1'b0;
        bin8   = 8'($urandom);
        wait_drain8();
        step();
    endtask

    initial begin
        logic found;
        rst_n   = 1'b0;
        start16 = 1'b0;
        bin16   = 16'd0;
        start8  = 1'b0;
        bin8    = 8'd0;
        #3;
        check_val("rst_busy", {31'd0, busy16}, 32'd0);
        check_val("rst_done", {31'd0, done16}, 32'd0);
        check_val("rst_bcd", {12'd0, bcd16}, 32'd0);
        check_val("rst_ovf", {31'd0, overflow16}, 32'd0);
        step();
        rst_n = 1'b1;
        step();

        run16(0);
        run16(65535);
        run16(1234);
        for (int i = 0; i < 6; i++) run16(int'($urandom_range(0, 65535)));

        // start pulsed again mid-conversion must be ignored
        start16 = 1'b1;
        bin16   = 16'd42;
        push16(42);
        step();
        for (int k = 1; k <= 16; k++) begin
            check_val("busy_hold", {31'd0, busy16}, 32'd1);
            if (k == 5) begin
                start16 = 1'b1;
                bin16   = 16'd99;
            end else begin
                start16 = 1'b0;
            end
            step();
        end
        check_val("busy_low_at_done", {31'd0, busy16}, 32'd0);
        wait_drain16();
        repeat (20) step();

        // back-to-back with start held high
        start16 = 1'b1;
        bin16   = 16'd7;
        push16(7);
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            step();
            if (done16) found = 1'b1;
        end
        check_val("b2b_first_done", {31'd0, found}, 32'd1);
        bin16 = 16'd8;
        push16(8);
        step();
        start16 = 1'b0;
        check_val("b2b_no_idle", {31'd0, busy16}, 32'd1);
        wait_drain16();
        step();

        // reset mid-conversion aborts without a later done
        start16 = 1'b1;
        bin16   = 16'd500;
        step();
        start16 = 1'b0;
        repeat (5) step();
        rst_n = 1'b0;
        #1;
        check_val("abort_busy", {31'd0, busy16}, 32'd0);
        check_val("abort_done", {31'd0, done16}, 32'd0);
        check_val("abort_bcd", {12'd0, bcd16}, 32'd0);
        check_val("abort_ovf", {31'd0, overflow16}, 32'd0);
        step();
        rst_n = 1'b1;
        repeat (25) step();
        check_val("abort_idle", {31'd0, busy16}, 32'd0);

        // narrow instance: overflow flag
        run8(100);
        run8(99);
        run8(255);
        run8(0);
        run8(57);

        repeat (3) step();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
